// File: rtl/gpio_pkg.sv
// gpio_button_reader shared types.
// Run FSM encoding and button roles.
package gpio_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RUN  = 2'd2
  } run_state_e;

  localparam int BTN_START = 0;
  localparam int BTN_ABORT = 1;

endpackage

// File: rtl/gpio_button_reader_if.sv
// Run-request handshake between the button
// reader (master) and the core controller.
interface gpio_run_if;

  logic       start_req;
  logic       start_ack;
  logic       cores_done;
  logic       busy;
  logic       abort_pulse;
  logic [7:0] run_count;

  modport master (
    output start_req,
    output busy,
    output abort_pulse,
    output run_count,
    input  start_ack,
    input  cores_done
  );

  modport slave (
    input  start_req,
    input  busy,
    input  abort_pulse,
    input  run_count,
    output start_ack,
    output cores_done
  );

endinterface

// File: rtl/gpio_button_reader_debounce.sv
// One button bit: synchroniser, stability
// counter, debounced level and edge pulses.
module gpio_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Level only moves after DEBOUNCE_CYCLES
  // consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        level <= synced;
        rise  <= synced;
        fall  <= ~synced;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_button_reader.sv
// Debounced push-buttons and the start/abort
// run-request FSM towards the core controller.
module gpio_button_reader
  import gpio_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  gpio_run_if.master         run
);

  run_state_e state_q;
  logic       start_p;
  logic       abort_p;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_in[i]),
      .level(btn_level[i]),
      .rise (btn_press[i]),
      .fall (btn_release[i])
    );
  end

  assign start_p = btn_press[BTN_START];
  assign abort_p = btn_press[BTN_ABORT];

  // Abort outranks ack in REQ and done in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      run.start_req   <= 1'b0;
      run.busy        <= 1'b0;
      run.abort_pulse <= 1'b0;
      run.run_count   <= 8'd0;
    end else begin
      run.abort_pulse <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_p) begin
            state_q       <= S_REQ;
            run.start_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (abort_p) begin
            state_q         <= S_IDLE;
            run.start_req   <= 1'b0;
            run.abort_pulse <= 1'b1;
          end else if (run.start_ack) begin
            state_q       <= S_RUN;
            run.start_req <= 1'b0;
            run.busy      <= 1'b1;
            run.run_count <= run.run_count + 8'd1;
          end
        end
        S_RUN: begin
          if (abort_p) begin
            state_q         <= S_IDLE;
            run.busy        <= 1'b0;
            run.abort_pulse <= 1'b1;
          end else if (run.cores_done) begin
            state_q  <= S_IDLE;
            run.busy <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          run.start_req <= 1'b0;
          run.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_button_reader.sv
// Directed self-checking bench for
// gpio_button_reader with default parameters.
module tb_gpio_button_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int checks = 0;
  int errors = 0;

  gpio_run_if run_if ();

  gpio_button_reader #(
    .NUM_BTN        (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .run        (run_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press start; returns with btn_press[0] visible.
  task automatic press_start();
    btn_in[0] = 1'b1;
    repeat (18) tick();
    btn_in[0] = 1'b0;
  endtask

  task automatic do_run();
    press_start();
    tick();
    run_if.start_ack = 1'b1;
    tick();
    run_if.start_ack = 1'b0;
    run_if.cores_done = 1'b1;
    tick();
    run_if.cores_done = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    logic [7:0] agg;
    rst = 1'b1;
    run_if.start_ack = 1'b0;
    run_if.cores_done = 1'b0;
    repeat (2) tick();
    agg = {run_if.start_req, run_if.busy,
           run_if.abort_pulse, |btn_level,
           |btn_press, |btn_release, 2'b00};
    checks++;
    if (agg !== 8'h00 || run_if.run_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: outs=%h cnt=%0d want 0/0",
               agg, run_if.run_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_level();
    logic saw_req;
    saw_req = 1'b0;
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      saw_req |= run_if.start_req;
      if (k == 17) begin
        checks++;
        if (btn_level[2] !== 1'b0) begin
          errors++;
          $display("FAIL lvl_early: got %b want 0",
                   btn_level[2]);
        end
      end
      if (k == 18) begin
        checks++;
        if (btn_level[2] !== 1'b1 ||
            btn_press[2] !== 1'b1) begin
          errors++;
          $display("FAIL lvl_rise: lvl=%b prs=%b want 1 1",
                   btn_level[2], btn_press[2]);
        end
      end
      if (k == 19) begin
        checks++;
        if (btn_press[2] !== 1'b0) begin
          errors++;
          $display("FAIL press_len: got %b want 0",
                   btn_press[2]);
        end
      end
    end
    checks++;
    if (saw_req !== 1'b0) begin
      errors++;
      $display("FAIL btn2_fsm: start_req=%b want 0",
               saw_req);
    end
    btn_in[2] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 18) begin
        checks++;
        if (btn_level[2] !== 1'b0 ||
            btn_release[2] !== 1'b1) begin
          errors++;
          $display("FAIL lvl_fall: lvl=%b rel=%b want 0 1",
                   btn_level[2], btn_release[2]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    btn_in[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen |= btn_level[0] | btn_press[0];
      seen |= run_if.start_req;
    end
    btn_in[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      seen |= btn_level[0] | btn_press[0];
      seen |= run_if.start_req;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch: seen=%b want 0", seen);
    end
  endtask

  task automatic test_run();
    int req_cyc;
    logic busy_ok;
    press_start();
    req_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (run_if.start_req === 1'b1) req_cyc++;
    end
    run_if.start_ack = 1'b1;
    tick();
    run_if.start_ack = 1'b0;
    checks++;
    if (req_cyc != 3 || run_if.start_req !== 1'b0 ||
        run_if.busy !== 1'b1 ||
        run_if.run_count !== 8'd1) begin
      errors++;
      $display("FAIL run_ack: req=%0d/%b busy=%b cnt=%0d want 3/0 1 1",
               req_cyc, run_if.start_req, run_if.busy,
               run_if.run_count);
    end
    busy_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      busy_ok &= run_if.busy;
    end
    run_if.cores_done = 1'b1;
    tick();
    run_if.cores_done = 1'b0;
    checks++;
    if (busy_ok !== 1'b1 || run_if.busy !== 1'b0 ||
        run_if.abort_pulse !== 1'b0) begin
      errors++;
      $display("FAIL run_done: held=%b busy=%b abt=%b want 1 0 0",
               busy_ok, run_if.busy, run_if.abort_pulse);
    end
    repeat (20) tick();
  endtask

  task automatic test_abort_run();
    press_start();
    tick();
    run_if.start_ack = 1'b1;
    tick();
    run_if.start_ack = 1'b0;
    btn_in[1] = 1'b1;
    repeat (18) tick();
    btn_in[1] = 1'b0;
    checks++;
    if (btn_press[1] !== 1'b1 || run_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: prs=%b busy=%b want 1 1",
               btn_press[1], run_if.busy);
    end
    tick();
    checks++;
    if (run_if.busy !== 1'b0 ||
        run_if.abort_pulse !== 1'b1) begin
      errors++;
      $display("FAIL abort_run: busy=%b abt=%b want 0 1",
               run_if.busy, run_if.abort_pulse);
    end
    tick();
    checks++;
    if (run_if.abort_pulse !== 1'b0) begin
      errors++;
      $display("FAIL abort_len: got %b want 0",
               run_if.abort_pulse);
    end
    run_if.cores_done = 1'b1;
    tick();
    run_if.cores_done = 1'b0;
    tick();
    checks++;
    if (run_if.busy !== 1'b0 || run_if.start_req !== 1'b0 ||
        run_if.run_count !== 8'd2) begin
      errors++;
      $display("FAIL post_abort: busy=%b req=%b cnt=%0d want 0 0 2",
               run_if.busy, run_if.start_req,
               run_if.run_count);
    end
    repeat (20) tick();
  endtask

  task automatic test_abort_ack();
    press_start();
    tick();
    btn_in[1] = 1'b1;
    repeat (18) tick();
    btn_in[1] = 1'b0;
    run_if.start_ack = 1'b1;
    tick();
    run_if.start_ack = 1'b0;
    checks++;
    if (run_if.abort_pulse !== 1'b1 ||
        run_if.start_req !== 1'b0 ||
        run_if.busy !== 1'b0 ||
        run_if.run_count !== 8'd2) begin
      errors++;
      $display("FAIL abort_ack: abt=%b req=%b busy=%b cnt=%0d want 1 0 0 2",
               run_if.abort_pulse, run_if.start_req,
               run_if.busy, run_if.run_count);
    end
    repeat (20) tick();
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 253; n++) do_run();
    checks++;
    if (run_if.run_count !== 8'd255) begin
      errors++;
      $display("FAIL cnt_255: got %0d want 255",
               run_if.run_count);
    end
    do_run();
    checks++;
    if (run_if.run_count !== 8'd0) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d want 0",
               run_if.run_count);
    end
  endtask

  task automatic test_reset_mid_run();
    btn_in[0] = 1'b1;
    repeat (18) tick();
    tick();
    run_if.start_ack = 1'b1;
    tick();
    run_if.start_ack = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (run_if.busy !== 1'b0 || run_if.start_req !== 1'b0 ||
        run_if.abort_pulse !== 1'b0 ||
        btn_level !== 4'h0 || run_if.run_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_run: busy=%b req=%b abt=%b lvl=%h cnt=%0d want 0",
               run_if.busy, run_if.start_req,
               run_if.abort_pulse, btn_level,
               run_if.run_count);
    end
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 18) begin
        checks++;
        if (btn_press[0] !== 1'b1 ||
            run_if.start_req !== 1'b0) begin
          errors++;
          $display("FAIL rst_press: prs=%b req=%b want 1 0",
                   btn_press[0], run_if.start_req);
        end
      end
      if (k == 19) begin
        checks++;
        if (run_if.start_req !== 1'b1) begin
          errors++;
          $display("FAIL rst_req: got %b want 1",
                   run_if.start_req);
        end
      end
    end
    btn_in[0] = 1'b0;
  endtask

  initial begin
    run_if.start_ack = 1'b0;
    run_if.cores_done = 1'b0;
    test_reset();
    test_level();
    test_glitch();
    test_run();
    test_abort_run();
    test_abort_ack();
    test_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_button_reader.md
# gpio_button_reader

Input-side GPIO block: samples raw board push-buttons, synchronises and debounces them, and turns the start/abort buttons into a handshaked run request for the multi-core controller. It is the inbound counterpart of the LED status driver: LEDs report run progress outward, this block brings operator commands inward. It sits between the board pins and the core-start logic, in the `clk` domain.

## Interface
- `NUM_BTN`, 4, number of raw button inputs; minimum 2 (bit 0 = start, bit 1 = abort, rest level/edge reporting only)
- `SYNC_STAGES`, 2, synchroniser flops per input; minimum 2
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles before a debounced level changes; minimum 2; counter width `$clog2(DEBOUNCE_CYCLES)`

- `clk`  input  1  system clock
- `rst`  input  1  synchronous, active-high reset
- `btn_in`  input  NUM_BTN  raw asynchronous button pins, active-high
- `btn_level`  output  NUM_BTN  debounced button levels
- `btn_press`  output  NUM_BTN  one-cycle pulse on debounced rising edge
- `btn_release`  output  NUM_BTN  one-cycle pulse on debounced falling edge
- `start_req`  output  1  run request to core controller, held until acknowledged
- `start_ack`  input  1  core controller accepts request
- `cores_done`  input  1  one-cycle or level indication that all cores finished
- `busy`  output  1  run in progress (request accepted, not yet done/aborted)
- `abort_pulse`  output  1  one-cycle pulse when a pending or running job is aborted
- `run_count`  output  8  number of accepted runs, wraps 255 -> 0

## Operation
- Reset (sync, active-high): all sync flops, debounce counters, `btn_level`, `btn_press`, `btn_release`, `start_req`, `busy`, `abort_pulse` = 0; `run_count` = 0; FSM = IDLE. Reset mid-run drops `start_req`/`busy` with no `abort_pulse`.
- Per bit: `SYNC_STAGES`-deep synchroniser -> debouncer. Debouncer: if synced value != `btn_level`, counter increments; when counter == `DEBOUNCE_CYCLES-1` and still mismatched, `btn_level` takes synced value and counter clears; any cycle where synced value == `btn_level` clears counter. Glitches shorter than `DEBOUNCE_CYCLES` cycles never change `btn_level`.
- `btn_press[i]`/`btn_release[i]` high for exactly the cycle in which `btn_level[i]` first shows its new value.
- Run FSM states IDLE, REQ, RUN:
  - IDLE: `btn_press[0]` -> REQ. All else ignored.
  - REQ: `start_req`=1. `btn_press[1]` -> IDLE with `abort_pulse`. Else `start_ack` sampled high -> RUN, `run_count`+1. `cores_done` ignored.
  - RUN: `busy`=1. `btn_press[1]` -> IDLE with `abort_pulse`. Else `cores_done` -> IDLE.
  - Abort has priority over `start_ack` in REQ and over `cores_done` in RUN; in REQ with simultaneous ack+abort, `run_count` does not increment.
  - `btn_press[0]` outside IDLE ignored (no queuing).
- A button held through reset is seen as a fresh press after the debounce latency post-reset.

## Timing
- Raw change stable before edge 1: `btn_level` updates at edge `SYNC_STAGES+DEBOUNCE_CYCLES` (18 with defaults); press/release pulse in same cycle.
- `start_req` asserts the cycle after `btn_press[0]`; deasserts the cycle after `start_ack` sampled; `busy` asserts that same cycle.
- `busy` deasserts the cycle after `cores_done` or abort press; `abort_pulse` is high in that same cycle, exactly one cycle.
- All outputs registered; no combinational path from any input to any output.

## Structure
- Shared package `gpio_pkg`: FSM state enum (IDLE/REQ/RUN), button index constants `BTN_START`=0, `BTN_ABORT`=1.
- Sub-module `gpio_debounce`: one bit, synchroniser + counter + level + edge pulses; instantiated `NUM_BTN` times via generate.
- Top holds run FSM and `run_count`.

## Test plan
- Raw `btn_in[2]` 0->1 held 30 cycles -> `btn_level[2]`=1 at edge 18, `btn_press[2]` one cycle, no FSM change.
- `btn_in[0]` glitch high 10 cycles then low -> `btn_level` stays 0, no press, `start_req` stays 0.
- Clean start press, `start_ack` 3 cycles after `start_req`, `cores_done` 20 cycles later -> `start_req` 3 cycles, `busy` high until cycle after done, `run_count`=1.
- Abort press during RUN -> `busy` falls, `abort_pulse` one cycle; `cores_done` then asserted -> no effect; `run_count` unchanged.
- Abort debounced in same cycle as `start_ack` in REQ -> IDLE, `abort_pulse`=1, `run_count` unchanged; 256 completed runs -> `run_count` wraps to 0.
- `rst` asserted mid-RUN with `btn_in[0]` held high -> all outputs 0 next cycle, no `abort_pulse`; new `start_req` appears 18 cycles after `rst` release +1.
